// File: rtl/pcie_ep_pkg.sv
// Shared definitions for the PCIe endpoint path: interrupt-controller FSM
// state encoding and default tuning values.
package pcie_ep_pkg;

    // Default event-count threshold for an immediate interrupt.
    localparam int COALESCE_CNT_DEF = 8;
    // Default number of cycles to wait for cfg_interrupt_rdy_n before giving up.
    localparam int RDY_TIMEOUT_DEF  = 1024;
    // Default widths of the moderation timer and the event counter.
    localparam int TIMER_W_DEF      = 16;
    localparam int CNT_W_DEF        = 8;

    // One-hot states of the interrupt controller.
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        REQ      = 4'b0010,
        WAIT_RDY = 4'b0100,
        RELEASE  = 4'b1000
    } irq_state_e;

endpackage

// File: rtl/irq_moderation_timer.sv
// Pending-event counter, moderation timer and interrupt trigger decision.
// The counter saturates; the timer only advances while the controller is idle
// with events pending, so arbitration and handshake time is not charged to it.
module irq_moderation_timer
    import pcie_ep_pkg::*;
#(
    parameter int COALESCE_CNT = COALESCE_CNT_DEF,
    parameter int TIMER_W      = TIMER_W_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic               trn_clk,
    input  logic               reset,
    input  logic               rx_event_i,
    input  logic               host_irq_en_i,
    input  logic [TIMER_W-1:0] irq_timeout_i,
    input  logic               idle_i,
    input  logic               send_done_i,
    output logic [CNT_W-1:0]   evt_cnt_o,
    output logic               trigger_o
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [TIMER_W-1:0] TMR_MAX   = '1;
    localparam logic [CNT_W-1:0]   COAL_TH   = CNT_W'(COALESCE_CNT);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               expired;

    // Next-state for the event counter and the moderation timer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = cnt_q;
        timer_d = timer_q;

        // A completed send clears the count, but an event landing in that same
        // cycle must not be lost, so it becomes the first pending event.
        if (send_done_i) begin
            cnt_d = rx_event_i ? CNT_W'(1) : '0;
        end else if (rx_event_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (send_done_i || cnt_q == '0) begin
            timer_d = '0;
        end else if (idle_i && timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Counter and timer registers.
    always_ff @(posedge trn_clk) begin
        // NOTE: reset is sampled on the clock edge; state registers use non-blocking assignments.
        if (reset) begin
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    // A zero timeout disables time-based moderation entirely.
    assign expired   = (irq_timeout_i != '0) && (timer_q >= irq_timeout_i);
    assign trigger_o = host_irq_en_i && (cnt_q != '0) && ((cnt_q >= COAL_TH) || expired);
    assign evt_cnt_o = cnt_q;

endmodule

// File: rtl/pcie_irq_ctrl.sv
// MSI interrupt generator with event coalescing. Requests the endpoint from
// the arbiter, drives the cfg_interrupt handshake while it owns the endpoint,
// and aborts with a sticky error if the core never acknowledges.
module pcie_irq_ctrl
    import pcie_ep_pkg::*;
#(
    parameter int COALESCE_CNT = COALESCE_CNT_DEF,
    parameter int TIMER_W      = TIMER_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int RDY_TIMEOUT  = RDY_TIMEOUT_DEF
) (
    input  logic               trn_clk,
    input  logic               reset,
    input  logic               rx_event,
    input  logic               host_irq_en,
    input  logic [TIMER_W-1:0] irq_timeout,
    output logic               intctrl_req_ep,
    input  logic               intctrl_turn,
    output logic               intctrl_driven,
    output logic               cfg_interrupt_n,
    input  logic               cfg_interrupt_rdy_n,
    output logic               irq_err,
    output logic [CNT_W-1:0]   evt_cnt
);

    localparam int             WD_W    = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RDY_TIMEOUT - 1);

    irq_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            drv_q, drv_d;
    logic            cfg_n_q, cfg_n_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            send_done;
    logic            trigger;

    irq_moderation_timer #(
        .COALESCE_CNT (COALESCE_CNT),
        .TIMER_W      (TIMER_W),
        .CNT_W        (CNT_W)
    ) u_mod (
        .trn_clk       (trn_clk),
        .reset         (reset),
        .rx_event_i    (rx_event),
        .host_irq_en_i (host_irq_en),
        .irq_timeout_i (irq_timeout),
        .idle_i        (state_q == IDLE),
        .send_done_i   (send_done),
        .evt_cnt_o     (evt_cnt),
        .trigger_o     (trigger)
    );

    // Next-state and registered-output decisions of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        drv_d     = drv_q;
        cfg_n_d   = cfg_n_q;
        err_d     = err_q;
        wd_d      = wd_q;
        send_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            // The grant cannot be refused, so losing host_irq_en here is ignored.
            REQ: begin
                if (intctrl_turn) begin
                    req_d   = 1'b0;
                    drv_d   = 1'b1;
                    cfg_n_d = 1'b0;
                    wd_d    = '0;
                    state_d = WAIT_RDY;
                end
            end
            // Acceptance wins over the watchdog if both land in the same cycle.
            WAIT_RDY: begin
                if (!cfg_interrupt_rdy_n) begin
                    cfg_n_d   = 1'b1;
                    send_done = 1'b1;
                    state_d   = RELEASE;
                end else if (wd_q == WD_LAST) begin
                    cfg_n_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            // One cycle with cfg_interrupt_n already high before giving up the endpoint.
            RELEASE: begin
                drv_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                drv_d   = 1'b0;
                cfg_n_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and handshake output registers.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            drv_q   <= 1'b0;
            cfg_n_q <= 1'b1;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            drv_q   <= drv_d;
            cfg_n_q <= cfg_n_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign intctrl_req_ep  = req_q;
    assign intctrl_driven  = drv_q;
    assign cfg_interrupt_n = cfg_n_q;
    assign irq_err         = err_q;

endmodule
